rd_burst_addr_seq: RTL and testbench
====================================

# rd_burst_addr_seq

Parametrised read-address sequencer for the DSO acquisition memory read-back path. After a trigger it walks the circular capture buffer in DDR and issues burst-aligned read commands to the memory controller through a valid/ready handshake. It supports a selectable ring depth, a configurable burst count, abort, and completion signalling. It sits between the acquisition control logic (start address, depth, length) and the DDR controller's read command port.

## Interface
Parameters:
- ADDR_W, 28, DDR address width in 64-bit word units.
- CNT_W, 27, width of the burst-count and issued-count fields.
- BURST_BEATS, 8, address increment per command. Must be a power of two, at least 2.
- MIN_WIN_BITS, 13, ring-window width in bits when depth_ctrl = 0.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request: latch the configuration and begin. Ignored while busy.
- abort  in  1  stop immediately and return to IDLE.
- depth_ctrl  in  4  ring size select. Window bits WB = min(MIN_WIN_BITS + depth_ctrl, ADDR_W).
- start_addr  in  ADDR_W  first read address (trigger-derived).
- num_bursts  in  CNT_W  number of commands to issue. 0 means none.
- cmd_valid  out  1  read command valid.
- cmd_ready  in  1  controller accepts the command.
- cmd_addr  out  ADDR_W  burst-aligned read address.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse on normal completion.
- issued_cnt  out  CNT_W  number of commands accepted in the current or last run.

## Operation
- Reset values: cmd_valid=0, cmd_addr=0, busy=0, done=0, issued_cnt=0; FSM in IDLE.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE: when start=1, latch start_addr, depth_ctrl and num_bursts; clear issued_cnt; go to LOAD.
- LOAD:
  - Build mask = 2^WB−1.
  - Set offset = start_addr & mask, with the low log2(BURST_BEATS) bits cleared.
  - If num_bursts = 0, go to FIN. Otherwise go to RUN with cmd_valid=1.
- RUN:
  - cmd_addr = {zeros above WB, offset[WB-1:0]}.
  - On cmd_valid && cmd_ready: offset ← (offset + BURST_BEATS) & mask, and issued_cnt += 1.
  - The accept that brings issued_cnt to num_bursts clears cmd_valid and moves to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Wrap-around: the offset rolls from mask+1−BURST_BEATS to 0 inside the window. Bits above WB are always 0.
- Handshake rules:
  - While cmd_valid=1 and cmd_ready=0, cmd_addr holds stable and cmd_valid stays high.
  - cmd_valid drops without acceptance only on abort.
- abort has priority over every other input, in any state:
  - Next state is IDLE, and cmd_valid=0 from the next cycle.
  - done is not asserted.
  - A handshake that completes in the same cycle as abort still counts in issued_cnt.
- start together with abort in IDLE: abort wins and start is ignored.
- start while busy: ignored. The configuration inputs are only sampled on an accepted start.
- Arithmetic is unsigned, modulo 2^WB. issued_cnt does not wrap, because it stops at num_bursts.

## Timing
- Accepted start at edge 0 → LOAD during cycle 1 → cmd_valid=1 with the first cmd_addr after edge 2. Start-to-first-command latency is 2 clocks.
- Throughput: one command per clock while cmd_ready=1.
- Last accept at edge n → cmd_valid=0 and done=1 after edge n+1 → IDLE after edge n+2.
- num_bursts=0: start edge 0 → done pulse after edge 2.
- busy rises one cycle after the accepted start and falls in the cycle after the done pulse.
- Reset mid-run: all outputs go to their reset values asynchronously. Reset release is synchronised by the parent.

## Structure
- Shared package rd_seq_pkg holds:
  - the FSM state encoding (2 bits),
  - the window-bits function WB(depth_ctrl),
  - the default parameters ADDR_W=28, CNT_W=27, BURST_BEATS=8.
- One sub-module: rd_win_mask, a combinational WB→mask decoder with output registered in LOAD, reused by the write-side generator.
- The rest is a single FSM, plus the offset register and the issued counter.

## Test plan
- Basic run: depth_ctrl=0 (WB=13), start_addr=0x0100, num_bursts=4, cmd_ready=1 → cmd_addr 0x100, 0x108, 0x110, 0x118 on consecutive cycles; done 1 cycle after the last accept; issued_cnt=4.
- Wrap: depth_ctrl=0, start_addr=0x1FF3, num_bursts=3 → 0x1FF0, 0x1FF8, 0x0000.
- Backpressure: cmd_ready toggles 1,0,0,1,1 → each address is held while stalled; no addresses are skipped or repeated.
- Abort: abort on the cycle of the 2nd accept, with num_bursts=10 → issued_cnt=2, cmd_valid=0 the next cycle, no done, state IDLE.
- Zero length and start while busy:
  - num_bursts=0 → done after edge 2 with no cmd_valid.
  - A second start during RUN → no effect on addresses or the count.
- Full depth: depth_ctrl=15 (WB=28), start_addr=0xFFFFFF8, num_bursts=2 → 0xFFFFFF8, then 0x0000000.

Source files
------------

// File: rtl/rd_seq_pkg.sv
// Shared definitions for the DDR read-address sequencer and its window-mask decoder.
// Holds the FSM encoding, default geometry and the ring-window width function.
package rd_seq_pkg;

  localparam int unsigned DefAddrW      = 28;
  localparam int unsigned DefCntW       = 27;
  localparam int unsigned DefBurstBeats = 8;
  localparam int unsigned DefMinWinBits = 13;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StFin  = 2'd3
  } state_e;

  // Ring window width: the base window grows by one bit per depth step, capped at the bus width.
  function automatic int unsigned win_bits(input logic [3:0]  depth_ctrl,
                                           input int unsigned min_bits,
                                           input int unsigned addr_w);
    int unsigned wb;
    wb = min_bits + int'(depth_ctrl);
    if (wb > addr_w) begin
      wb = addr_w;
    end
    return wb;
  endfunction

endpackage

// File: rtl/rd_win_mask.sv
// Combinational decoder from ring-depth select to a low-order window mask (2^WB - 1).
// Shared with the write-side address generator.
module rd_win_mask
  import rd_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned MIN_WIN_BITS = DefMinWinBits
) (
  input  logic [3:0]        depth_ctrl,
  output logic [ADDR_W-1:0] mask
);

  int unsigned wb;

  assign wb = win_bits(depth_ctrl, MIN_WIN_BITS, ADDR_W);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      mask[i] = (i < wb);
    end
  end

endmodule

// File: rtl/rd_burst_addr_seq.sv
// Read-address sequencer: walks a circular capture window in DDR after a trigger and
// issues burst-aligned read commands over a valid/ready handshake.
module rd_burst_addr_seq
  import rd_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned BURST_BEATS  = DefBurstBeats,
  parameter int unsigned MIN_WIN_BITS = DefMinWinBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        depth_ctrl,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_bursts,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt
);

  localparam logic [ADDR_W-1:0] BeatInc   = ADDR_W'(BURST_BEATS);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(BURST_BEATS - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] start_q;
  logic [3:0]        depth_q;
  logic [CNT_W-1:0]  num_q;
  logic [ADDR_W-1:0] mask_d, mask_q;
  logic [ADDR_W-1:0] offset_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              cmd_valid_q, cmd_valid_d;
  logic              start_ok, accept, last_accept;

  rd_win_mask #(
    .ADDR_W      (ADDR_W),
    .MIN_WIN_BITS(MIN_WIN_BITS)
  ) u_win_mask (
    .depth_ctrl(depth_q),
    .mask      (mask_d)
  );

  assign start_ok    = (state_q == StIdle) && start && !abort;
  assign accept      = (state_q == StRun) && cmd_valid_q && cmd_ready;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign last_accept = (cnt_inc == num_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StLoad;
        StLoad:  state_d = (num_q == '0) ? StFin : StRun;
        StRun:   if (accept && last_accept) state_d = StFin;
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFin);
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    if (abort) begin
      cmd_valid_d = 1'b0;
    end else if (state_q == StLoad) begin
      cmd_valid_d = (num_q != '0);
    end else if (accept && last_accept) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Configuration, window and address datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q     <= '0;
      depth_q     <= '0;
      num_q       <= '0;
      mask_q      <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      if (start_ok) begin
        start_q <= start_addr;
        depth_q <= depth_ctrl;
        num_q   <= num_bursts;
        cnt_q   <= '0;
      end
      if (state_q == StLoad && !abort) begin
        mask_q   <= mask_d;
        offset_q <= start_q & mask_d & AlignMask;
      end
      // A handshake completing alongside abort still counts.
      if (accept) begin
        offset_q <= (offset_q + BeatInc) & mask_q;
        cnt_q    <= cnt_inc;
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_addr   = offset_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_rd_burst_addr_seq.sv
// Directed self-checking bench for rd_burst_addr_seq with default parameters.
module tb_rd_burst_addr_seq;

  localparam int unsigned AW = 28;
  localparam int unsigned CW = 27;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    depth_ctrl;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] num_bursts;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued_cnt;

  int checks;
  int failures;

  rd_burst_addr_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .depth_ctrl(depth_ctrl),
    .start_addr(start_addr),
    .num_bursts(num_bursts),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .busy      (busy),
    .done      (done),
    .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] d, input logic [AW-1:0] a, input logic [CW-1:0] n);
    depth_ctrl = d;
    start_addr = a;
    num_bursts = n;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_a [5];
    logic          rdy   [5];

    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    depth_ctrl = '0;
    start_addr = '0;
    num_bursts = '0;
    cmd_ready  = 1'b0;
    #12;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_addr", 64'(cmd_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt", 64'(issued_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic run
    cmd_ready = 1'b1;
    launch(4'd0, 28'h0100, 27'd4);
    check("basic_load_busy", 64'(busy), 64'd1);
    check("basic_load_valid", 64'(cmd_valid), 64'd0);
    tick();
    exp_a[0] = 28'h100; exp_a[1] = 28'h108; exp_a[2] = 28'h110; exp_a[3] = 28'h118;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_valid%0d", i), 64'(cmd_valid), 64'd1);
      check($sformatf("basic_addr%0d", i), 64'(cmd_addr), 64'(exp_a[i]));
      tick();
    end
    check("basic_done", 64'(done), 64'd1);
    check("basic_valid_off", 64'(cmd_valid), 64'd0);
    check("basic_cnt", 64'(issued_cnt), 64'd4);
    tick();
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_idle", 64'(busy), 64'd0);

    // Wrap inside a 13-bit window
    launch(4'd0, 28'h1FF3, 27'd3);
    tick();
    exp_a[0] = 28'h1FF0; exp_a[1] = 28'h1FF8; exp_a[2] = 28'h0000;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_addr%0d", i), 64'(cmd_addr), 64'(exp_a[i]));
      tick();
    end
    check("wrap_done", 64'(done), 64'd1);
    check("wrap_cnt", 64'(issued_cnt), 64'd3);
    tick();

    // Backpressure
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1; rdy[4] = 1'b1;
    exp_a[0] = 28'h200; exp_a[1] = 28'h208; exp_a[2] = 28'h208; exp_a[3] = 28'h208;
    exp_a[4] = 28'h210;
    launch(4'd0, 28'h0200, 27'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd_ready = rdy[i];
      check($sformatf("bp_valid%0d", i), 64'(cmd_valid), 64'd1);
      check($sformatf("bp_addr%0d", i), 64'(cmd_addr), 64'(exp_a[i]));
      tick();
    end
    check("bp_done", 64'(done), 64'd1);
    check("bp_cnt", 64'(issued_cnt), 64'd3);
    cmd_ready = 1'b1;
    tick();

    // Abort on the second accept
    launch(4'd0, 28'h0000, 27'd10);
    tick();
    check("abort_addr0", 64'(cmd_addr), 64'h0);
    tick();
    check("abort_addr1", 64'(cmd_addr), 64'h8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_cnt", 64'(issued_cnt), 64'd2);
    check("abort_valid", 64'(cmd_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    check("abort_done_later", 64'(done), 64'd0);

    // Zero length
    launch(4'd0, 28'h0040, 27'd0);
    check("zero_load_valid", 64'(cmd_valid), 64'd0);
    tick();
    check("zero_done", 64'(done), 64'd1);
    check("zero_valid", 64'(cmd_valid), 64'd0);
    check("zero_cnt", 64'(issued_cnt), 64'd0);
    tick();
    check("zero_idle", 64'(busy), 64'd0);

    // Second start during RUN is ignored
    launch(4'd0, 28'h0300, 27'd3);
    tick();
    exp_a[0] = 28'h300; exp_a[1] = 28'h308; exp_a[2] = 28'h310;
    start_addr = 28'h0500;
    num_bursts = 27'd1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_start_addr%0d", i), 64'(cmd_addr), 64'(exp_a[i]));
      tick();
      start = 1'b0;
    end
    check("busy_start_done", 64'(done), 64'd1);
    check("busy_start_cnt", 64'(issued_cnt), 64'd3);
    tick();

    // Start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    tick();
    check("start_abort_valid", 64'(cmd_valid), 64'd0);

    // Full 28-bit window
    launch(4'd15, 28'hFFFFFF8, 27'd2);
    tick();
    check("full_addr0", 64'(cmd_addr), 64'hFFFFFF8);
    tick();
    check("full_addr1", 64'(cmd_addr), 64'h0);
    tick();
    check("full_done", 64'(done), 64'd1);
    check("full_cnt", 64'(issued_cnt), 64'd2);
    tick();

    // Depth 1: 14-bit window, high start bits dropped
    launch(4'd1, 28'hABC3FF8, 27'd2);
    tick();
    check("d1_addr0", 64'(cmd_addr), 64'h3FF8);
    tick();
    check("d1_addr1", 64'(cmd_addr), 64'h0);
    tick();
    tick();

    // Asynchronous reset mid-run
    launch(4'd0, 28'h0400, 27'd5);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(cmd_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cnt", 64'(issued_cnt), 64'd0);
    check("arst_addr", 64'(cmd_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
